// File: rtl/spec_reg_if.sv
// -----------------------------------------------------------------------------
// spec_reg_if
//   Control/data bundle for one bus-attached datapath register.
//   The shared tri-state bus itself is not part of this bundle: several
//   registers attach to the same bus wire while each keeps its own bundle.
//   That is why the bus is a plain port on spec_reg.
//
// Signals
//   in  WIDTH  data word to capture on a load
//   l   1      load enable, sampled on the rising clock edge
//   t   1      transfer (bus output) enable, combinational
//
// Modports
//   master  control unit side (drives in/l/t)
//   slave   register side (receives in/l/t)
// -----------------------------------------------------------------------------
interface spec_reg_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] in;
  logic             l;
  logic             t;

  modport master (
    output in,
    output l,
    output t
  );

  modport slave (
    input in,
    input l,
    input t
  );
endinterface

// File: rtl/spec_reg.sv
// -----------------------------------------------------------------------------
// spec_reg
//   Special-purpose datapath register with a tri-state bus driver.
//   - A word is captured from ctl.in on a rising clk edge while ctl.l is high.
//   - The stored word is driven onto bus only while ctl.t is high.
//   - While ctl.t is low, every bus bit is released (high-Z), so other
//     registers on the same bus can drive it without contention.
//   - The bus always shows the stored word, never ctl.in. There is no
//     flow-through path: a load is visible on the bus only after its edge.
//
// Parameters
//   WIDTH      data width of ctl.in, bus and the stored word
//   RESET_VAL  value forced into the register by reset
//
// Ports
//   clk    in     1      system clock, rising-edge active
//   reset  in     1      asynchronous, active-high reset
//   ctl    slave  -      in / l / t bundle (see spec_reg_if)
//   bus    out    WIDTH  tri-state shared bus, driven only when ctl.t = 1
// -----------------------------------------------------------------------------
module spec_reg #(
  parameter int               WIDTH     = 16,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             reset,
  spec_reg_if.slave        ctl,
  output wire  [WIDTH-1:0] bus
);

  logic [WIDTH-1:0] q_r;

  // Storage: reset wins over load at all times, load captures ctl.in, otherwise hold.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_r <= RESET_VAL;
    end else if (ctl.l) begin
      q_r <= ctl.in;
    end else begin
      q_r <= q_r;
    end
  end

  // Bus driver: transparent to t with no clock involvement. Released means all bits high-Z.
  assign bus = ctl.t ? q_r : {WIDTH{1'bz}};

endmodule

// File: tb/tb_spec_reg.sv
// -----------------------------------------------------------------------------
// tb_spec_reg
//   Directed bench for spec_reg. Two registers share one bus. The bus has
//   weak pull-ups, so a fully released bus reads as 16'hFFFF. This lets the
//   released state be observed and distinguished from a driven value.
//   Stimulus values are chosen so that no driven word equals 16'hFFFF.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_spec_reg;

  localparam int WIDTH = 16;
  localparam logic [WIDTH-1:0] RELEASED = 16'hFFFF;

  logic clk;
  logic reset;
  wire  [WIDTH-1:0] bus;

  int checks;
  int errors;

  spec_reg_if #(.WIDTH(WIDTH)) ifa ();
  spec_reg_if #(.WIDTH(WIDTH)) ifb ();

  spec_reg #(.WIDTH(WIDTH), .RESET_VAL(16'h0000)) dut_a (
    .clk   (clk),
    .reset (reset),
    .ctl   (ifa.slave),
    .bus   (bus)
  );

  spec_reg #(.WIDTH(WIDTH), .RESET_VAL(16'h0000)) dut_b (
    .clk   (clk),
    .reset (reset),
    .ctl   (ifb.slave),
    .bus   (bus)
  );

  // Weak pull-ups make the released bus observable.
  for (genvar i = 0; i < WIDTH; i++) begin : g_pu
    pullup (bus[i]);
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic test_reset();
    reset  = 1'b1;
    ifa.l  = 1'b0; ifa.t = 1'b0; ifa.in = 16'h0000;
    ifb.l  = 1'b0; ifb.t = 1'b0; ifb.in = 16'h0000;
    #2;
    ifa.t = 1'b1;
    #1;
    checks++;
    if (bus !== 16'h0000) begin
      errors++;
      $display("FAIL reset_bus: bus=%h expected %h", bus, 16'h0000);
    end
    ifa.t = 1'b0;
    #1;
    checks++;
    if (bus !== RELEASED) begin
      errors++;
      $display("FAIL reset_release: bus=%h expected released %h", bus, RELEASED);
    end
    ifb.t = 1'b1;
    #1;
    checks++;
    if (bus !== 16'h0000) begin
      errors++;
      $display("FAIL reset_bus_b: bus=%h expected %h", bus, 16'h0000);
    end
    ifb.t = 1'b0;
    @(posedge clk);
    #3;
    reset = 1'b0;
  endtask

  task automatic test_load();
    @(negedge clk);
    ifa.in = 16'd100;
    ifa.l  = 1'b1;
    @(posedge clk);
    #1;
    ifa.l  = 1'b0;
    ifa.in = 16'h1111;
    ifa.t  = 1'b1;
    #1;
    checks++;
    if (bus !== 16'h0064) begin
      errors++;
      $display("FAIL load_100: bus=%h expected %h", bus, 16'h0064);
    end
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      checks++;
      if (bus !== 16'h0064) begin
        errors++;
        $display("FAIL load_hold_%0d: bus=%h expected %h", k, bus, 16'h0064);
      end
    end
  endtask

  task automatic test_load_during_transfer();
    ifa.in = 16'hBEEF;
    ifa.l  = 1'b1;
    ifa.t  = 1'b1;
    #2;
    checks++;
    if (bus !== 16'h0064) begin
      errors++;
      $display("FAIL lt_before_edge: bus=%h expected old %h", bus, 16'h0064);
    end
    @(posedge clk);
    #1;
    ifa.l = 1'b0;
    checks++;
    if (bus !== 16'hBEEF) begin
      errors++;
      $display("FAIL lt_after_edge: bus=%h expected new %h", bus, 16'hBEEF);
    end
  endtask

  task automatic test_transfer_toggle();
    @(posedge clk);
    #1;
    ifa.t = 1'b1;
    #1;
    checks++;
    if (bus !== 16'hBEEF) begin
      errors++;
      $display("FAIL toggle_on1: bus=%h expected %h", bus, 16'hBEEF);
    end
    ifa.t = 1'b0;
    #1;
    checks++;
    if (bus !== RELEASED) begin
      errors++;
      $display("FAIL toggle_off: bus=%h expected released %h", bus, RELEASED);
    end
    ifa.t = 1'b1;
    #1;
    checks++;
    if (bus !== 16'hBEEF) begin
      errors++;
      $display("FAIL toggle_on2: bus=%h expected %h", bus, 16'hBEEF);
    end
    ifa.t = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (bus !== RELEASED) begin
      errors++;
      $display("FAIL toggle_off_edge: bus=%h expected released %h", bus, RELEASED);
    end
  endtask

  task automatic test_reset_midcycle();
    ifa.t = 1'b1;
    #1;
    checks++;
    if (bus !== 16'hBEEF) begin
      errors++;
      $display("FAIL rst_pre: bus=%h expected %h", bus, 16'hBEEF);
    end
    #1;
    reset = 1'b1;
    #1;
    checks++;
    if (bus !== 16'h0000) begin
      errors++;
      $display("FAIL rst_async: bus=%h expected %h", bus, 16'h0000);
    end
    ifa.in = 16'h5555;
    ifa.l  = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (bus !== 16'h0000) begin
      errors++;
      $display("FAIL rst_over_load: bus=%h expected %h", bus, 16'h0000);
    end
    reset = 1'b0;
    ifa.l = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (bus !== 16'h0000) begin
      errors++;
      $display("FAIL rst_after_release: bus=%h expected %h", bus, 16'h0000);
    end
    ifa.t = 1'b0;
  endtask

  task automatic test_two_drivers();
    @(negedge clk);
    ifa.in = 16'h1357; ifa.l = 1'b1;
    ifb.in = 16'h2468; ifb.l = 1'b1;
    @(posedge clk);
    #1;
    ifa.l = 1'b0; ifb.l = 1'b0;
    ifa.t = 1'b1; ifb.t = 1'b0;
    #1;
    checks++;
    if (bus !== 16'h1357 || $isunknown(bus)) begin
      errors++;
      $display("FAIL two_a: bus=%h expected %h", bus, 16'h1357);
    end
    ifa.t = 1'b0; ifb.t = 1'b1;
    #1;
    checks++;
    if (bus !== 16'h2468 || $isunknown(bus)) begin
      errors++;
      $display("FAIL two_b: bus=%h expected %h", bus, 16'h2468);
    end
    ifb.t = 1'b0;
    #1;
    checks++;
    if (bus !== RELEASED) begin
      errors++;
      $display("FAIL two_none: bus=%h expected released %h", bus, RELEASED);
    end
  endtask

  task automatic test_back_to_back();
    logic [WIDTH-1:0] vals [4];
    vals[0] = 16'h0001;
    vals[1] = 16'h8000;
    vals[2] = 16'hA5A5;
    vals[3] = 16'h0000;
    @(negedge clk);
    ifa.t = 1'b1;
    ifa.l = 1'b1;
    for (int k = 0; k < 4; k++) begin
      ifa.in = vals[k];
      @(posedge clk);
      #1;
      checks++;
      if (bus !== vals[k]) begin
        errors++;
        $display("FAIL b2b_%0d: bus=%h expected %h", k, bus, vals[k]);
      end
    end
    ifa.l = 1'b0;
    ifa.t = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_load();
    test_load_during_transfer();
    test_transfer_toggle();
    test_reset_midcycle();
    test_two_drivers();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
